// File: rtl/vram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_arb_pkg
// Description : Shared types and default sizes for the VRAM access scheduler:
//               read-return tags, fill engine states, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_arb_pkg;

  localparam int C_ADDR_W   = 18;
  localparam int C_DATA_W   = 16;
  localparam int C_FB_WORDS = 76800;

  // Owner of a VRAM read travelling down the return pipe
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2
  } vram_tag_e;

  // Screen-fill engine states
  typedef enum logic [0:0] {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_e;

endpackage : vram_arb_pkg
`default_nettype wire

// File: rtl/vram_fill_engine.sv
`default_nettype none
// ============================================================================
// Module      : vram_fill_engine
// Description : Screen-fill engine. Captures a fill word on start and writes
//               it to addresses 0..FB_WORDS-1, one word per granted slot.
//               Presents a req/gnt pair to the VRAM arbiter. Only built when
//               VRAM_FILL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_fill_engine
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W   = C_ADDR_W,
  parameter int DATA_W   = C_DATA_W,
  parameter int FB_WORDS = C_FB_WORDS
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              fill_gnt,
  output logic              fill_req,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_busy
);

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  fill_state_e       r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_value;
  logic              r_busy;

  // Fill FSM: start captures the word, each grant advances the counter,
  // the grant at the last address ends the run (counter never wraps)
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state <= FILL_IDLE;
      r_addr  <= '0;
      r_value <= '0;
      r_busy  <= 1'b0;
    end else begin
      // busy lags the state by one cycle at the end so it stays high
      // through the cycle in which the final write is on the bus
      r_busy <= (r_state == FILL_RUN) || fill_start;
      case (r_state)
        FILL_IDLE: begin
          if (fill_start) begin
            r_state <= FILL_RUN;
            r_addr  <= '0;
            r_value <= fill_value;
          end
        end
        FILL_RUN: begin
          if (fill_gnt) begin
            if (r_addr == C_LAST_ADDR) begin
              r_state <= FILL_IDLE;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        default: r_state <= FILL_IDLE;
      endcase
    end
  end

  assign fill_req  = (r_state == FILL_RUN);
  assign fill_addr = r_addr;
  assign fill_data = r_value;
  assign fill_busy = r_busy;

endmodule : vram_fill_engine
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Single-port VRAM scheduler. Display scanout has absolute
//               priority, then the host port, then (optionally) the fill
//               engine. Arbitration is registered; the winner drives mem_*
//               in the following cycle. Read data returns through a tag pipe.
//               Optional feature macro: VRAM_FILL_EN (fill engine + ports,
//               FB_WORDS parameter).
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W   = C_ADDR_W,
  parameter int DATA_W   = C_DATA_W,
`ifdef VRAM_FILL_EN
  parameter int FB_WORDS = C_FB_WORDS,
`endif
  parameter int RD_LAT   = 2
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
`ifdef VRAM_FILL_EN
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_host_gnt;
  logic [DATA_W-1:0] r_disp_data;
  logic [DATA_W-1:0] r_host_rdata;
  vram_tag_e         r_tag [0:RD_LAT];
  vram_tag_e         w_tag_in;
  logic              w_host_elig;
  logic              w_disp_valid;
  logic              w_host_rvalid;

  // A held host request that was granted at the previous edge must not be
  // granted again while the host is still seeing host_gnt
  assign w_host_elig = host_req && !r_host_gnt;

`ifdef VRAM_FILL_EN
  logic              w_fill_req;
  logic              w_fill_gnt;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [DATA_W-1:0] w_fill_data;

  assign w_fill_gnt = w_fill_req && !disp_req && !w_host_elig;

  vram_fill_engine #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .FB_WORDS (FB_WORDS)
  ) u_fill (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .fill_gnt   (w_fill_gnt),
    .fill_req   (w_fill_req),
    .fill_addr  (w_fill_addr),
    .fill_data  (w_fill_data),
    .fill_busy  (fill_busy)
  );
`endif

  // Registered priority select: display, host, fill; idle keeps addr/wdata
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_host_gnt  <= 1'b0;
    end else begin
      r_mem_we   <= 1'b0;
      r_host_gnt <= 1'b0;
      if (disp_req) begin
        r_mem_addr <= disp_addr;
      end else if (w_host_elig) begin
        r_mem_addr  <= host_addr;
        r_mem_wdata <= host_wdata;
        r_mem_we    <= host_we;
        r_host_gnt  <= 1'b1;
`ifdef VRAM_FILL_EN
      end else if (w_fill_req) begin
        r_mem_addr  <= w_fill_addr;
        r_mem_wdata <= w_fill_data;
        r_mem_we    <= 1'b1;
`endif
      end
    end
  end

  // Tag for the access issued at this edge; writes and idle slots carry NONE
  always_comb begin
    w_tag_in = TAG_NONE;
    if (disp_req) begin
      w_tag_in = TAG_DISP;
    end else if (w_host_elig && !host_we) begin
      w_tag_in = TAG_HOST;
    end
  end

  // Tag shift register: stage i is live in the (i+1)th cycle after issue,
  // so the last stage lines up with mem_rdata of that read
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        r_tag[i] <= TAG_NONE;
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Valid pulses are suppressed while RESET is high so no in-flight read
  // can leak out during reset
  assign w_disp_valid  = !RESET && (r_tag[RD_LAT] == TAG_DISP);
  assign w_host_rvalid = !RESET && (r_tag[RD_LAT] == TAG_HOST);

  // Hold the last returned word for each requester between valid pulses
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_disp_data  <= '0;
      r_host_rdata <= '0;
    end else begin
      if (w_disp_valid) begin
        r_disp_data <= mem_rdata;
      end
      if (w_host_rvalid) begin
        r_host_rdata <= mem_rdata;
      end
    end
  end

  assign disp_valid  = w_disp_valid;
  assign disp_data   = w_disp_valid ? mem_rdata : r_disp_data;
  assign host_rvalid = w_host_rvalid;
  assign host_rdata  = w_host_rvalid ? mem_rdata : r_host_rdata;
  assign host_gnt    = r_host_gnt;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_we      = r_mem_we;

endmodule : vram_arbiter
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed self-checking bench for vram_arbiter with a
//               two-cycle-latency VRAM model. Fill scenario is built only
//               when VRAM_FILL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 2;
  localparam int FB_WORDS = 16;

  logic              CLOCK_50 = 1'b0;
  logic              RESET;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
`ifdef VRAM_FILL_EN
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
`endif
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  vram_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
`ifdef VRAM_FILL_EN
    .FB_WORDS (FB_WORDS),
`endif
    .RD_LAT   (RD_LAT)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
`ifdef VRAM_FILL_EN
    .fill_start  (fill_start),
    .fill_value  (fill_value),
    .fill_busy   (fill_busy),
`endif
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  // VRAM model: write on the edge, read data valid RD_LAT cycles after the
  // address cycle; a bench-side port preloads contents
  logic [DATA_W-1:0] vram    [0:1023];
  logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];
  logic              tb_we = 1'b0;
  logic [9:0]        tb_addr = '0;
  logic [DATA_W-1:0] tb_data = '0;

  always @(posedge CLOCK_50) begin
    if (tb_we) vram[tb_addr] <= tb_data;
    else if (mem_we) vram[mem_addr[9:0]] <= mem_wdata;
    rd_pipe[0] <= vram[mem_addr[9:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic outs_nonzero();
    logic r;
    r = |{disp_data, disp_valid, host_gnt, host_rdata, host_rvalid, mem_addr, mem_wdata, mem_we};
`ifdef VRAM_FILL_EN
    r = r | fill_busy;
`endif
    return r;
  endfunction

  task automatic preload(input logic [9:0] a, input logic [DATA_W-1:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    step();
    tb_we = 1'b0;
  endtask

  // Hold a host request until granted (bounded); returns in the gnt cycle
  task automatic host_op(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output logic ok);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      step();
      if (host_gnt) ok = 1'b1;
    end
    host_req = 1'b0;
    check_eq("host_gnt_seen", ok, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       ok;
    logic [2:0] hist;
    int         hidx;
    int         grants_at_16;
    int         dj;
    int         dq[$];

    RESET = 1'b1;
    disp_req = 1'b0; disp_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
`ifdef VRAM_FILL_EN
    fill_start = 1'b0; fill_value = '0;
`endif
    step();
    preload(10'h100, 16'hABCD);
    for (int j = 0; j < 10; j++) preload(10'(10'h080 + j), 16'(16'hD000 + j));

    // Reset with random inputs: every output stays 0
    for (int c = 0; c < 3; c++) begin
      disp_req = 1'($urandom); disp_addr = 18'($urandom);
      host_req = 1'($urandom); host_we = 1'($urandom);
      host_addr = 18'($urandom); host_wdata = 16'($urandom);
`ifdef VRAM_FILL_EN
      fill_start = 1'($urandom); fill_value = 16'($urandom);
`endif
      step();
      check_eq("reset_outputs_zero", outs_nonzero(), 0);
    end
    RESET = 1'b0;
    disp_req = 1'b0; host_req = 1'b0; host_we = 1'b0;
`ifdef VRAM_FILL_EN
    fill_start = 1'b0;
`endif
    step();
    check_eq("idle_no_valid", {disp_valid, host_rvalid, mem_we}, 0);

    // Display read of 0x00100: address next cycle, data 3 cycles after req
    disp_req = 1'b1; disp_addr = 18'h00100;
    step();
    disp_req = 1'b0;
    check_eq("disp_mem_addr", mem_addr, 18'h00100);
    check_eq("disp_mem_we", mem_we, 0);
    step();
    check_eq("disp_valid_early", disp_valid, 0);
    step();
    check_eq("disp_valid", disp_valid, 1);
    check_eq("disp_data", disp_data, 16'hABCD);
    step();
    check_eq("disp_valid_pulse", disp_valid, 0);

    // Collision: display wins, host write goes one cycle later
    disp_req = 1'b1; disp_addr = 18'h00100;
    host_req = 1'b1; host_we = 1'b1; host_addr = 18'h00200; host_wdata = 16'h1234;
    step();
    disp_req = 1'b0;
    check_eq("coll_disp_first_addr", mem_addr, 18'h00100);
    check_eq("coll_host_not_yet", host_gnt, 0);
    step();
    host_req = 1'b0;
    check_eq("coll_host_gnt", host_gnt, 1);
    check_eq("coll_mem_we", mem_we, 1);
    check_eq("coll_mem_addr", mem_addr, 18'h00200);
    check_eq("coll_mem_wdata", mem_wdata, 16'h1234);
    check_eq("coll_disp_valid", disp_valid, 0);
    step();
    check_eq("coll_gnt_drop", {host_gnt, mem_we}, 0);
    check_eq("coll_disp_valid_late", {disp_valid, disp_data}, {1'b1, 16'hABCD});
    check_eq("coll_addr_held", mem_addr, 18'h00200);
    step();

    // Sustained load: display every other cycle plus 8 queued host writes
    hist = '0; hidx = 0; dj = 0; grants_at_16 = 0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 18'h00040; host_wdata = 16'h1000;
    for (int c = 0; c < 19; c++) begin
      if (c < 16 && (c % 2) == 0) begin
        disp_req = 1'b1; disp_addr = 18'(18'h00080 + dj);
        dq.push_back(16'hD000 + dj); dj++;
      end else begin
        disp_req = 1'b0;
      end
      step();
      hist = {hist[1:0], disp_req};
      if (host_gnt) begin
        check_eq("load_host_addr", mem_addr, 18'h00040 + hidx);
        check_eq("load_host_wdata", mem_wdata, 16'h1000 + hidx);
        check_eq("load_host_we", mem_we, 1);
        hidx++;
        if (hidx < 8) begin
          host_addr = 18'(18'h00040 + hidx); host_wdata = 16'(16'h1000 + hidx);
        end else begin
          host_req = 1'b0;
        end
      end
      if (c == 15) grants_at_16 = hidx;
      check_eq("load_disp_valid", disp_valid, hist[2]);
      if (hist[2] && dq.size() > 0) check_eq("load_disp_data", disp_data, dq.pop_front());
    end
    disp_req = 1'b0; host_req = 1'b0;
    check_eq("load_host_grants_16", grants_at_16, 8);

    // Readback of the host writes
    for (int i = 0; i < 8; i++) begin
      host_op(1'b0, 18'(18'h00040 + i), '0, ok);
      step();
      check_eq("rb_rvalid_early", host_rvalid, 0);
      step();
      check_eq("rb_rvalid", host_rvalid, 1);
      check_eq("rb_rdata", host_rdata, 16'h1000 + i);
    end
    step();

`ifdef VRAM_FILL_EN
    begin
      int   nfw;
      logic host_sent, host_new, host_done, last_prev;
      nfw = 0; host_sent = 0; host_new = 0; host_done = 0; last_prev = 0;
      fill_value = 16'h5A5A; fill_start = 1'b1;
      step();
      fill_start = 1'b0; fill_value = 16'h1111;
      check_eq("fill_busy_start", fill_busy, 1);
      for (int c = 0; c < 40; c++) begin
        if (nfw == 6 && !host_sent) begin
          host_req = 1'b1; host_we = 1'b1; host_addr = 18'h00002; host_wdata = 16'hBEEF;
          host_sent = 1'b1; host_new = 1'b1;
        end
        fill_start = (c == 10);
        step();
        if (last_prev) check_eq("fill_busy_drop", fill_busy, 0);
        last_prev = 1'b0;
        if (host_new) begin
          check_eq("fill_host_wins", host_gnt, 1);
          host_new = 1'b0;
        end
        if (host_gnt) begin
          check_eq("fill_host_addr", mem_addr, 18'h00002);
          check_eq("fill_host_wdata", mem_wdata, 16'hBEEF);
          host_req = 1'b0; host_done = 1'b1;
        end else if (mem_we) begin
          check_eq("fill_addr", mem_addr, nfw);
          check_eq("fill_data", mem_wdata, 16'h5A5A);
          if (nfw == FB_WORDS - 1) begin
            check_eq("fill_busy_last", fill_busy, 1);
            last_prev = 1'b1;
          end
          nfw++;
        end
      end
      fill_start = 1'b0;
      check_eq("fill_count", nfw, FB_WORDS);
      check_eq("fill_host_done", host_done, 1);
      check_eq("fill_idle", fill_busy, 0);
      for (int i = 0; i < FB_WORDS; i++)
        check_eq("fill_readback", vram[i], (i == 2) ? 16'hBEEF : 16'h5A5A);
    end
`endif

    // Reset the cycle after a host read grant: the read never returns
    host_op(1'b0, 18'h00047, '0, ok);
    step();
    RESET = 1'b1;
    check_eq("rst_mid_no_rvalid_a", host_rvalid, 0);
    step();
    check_eq("rst_mid_no_rvalid_b", host_rvalid, 0);
    step();
    check_eq("rst_mid_outputs_zero", outs_nonzero(), 0);
    RESET = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("post_rst_outputs_zero", outs_nonzero(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_vram_arbiter
`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM access scheduler on CLOCK_50. It shares one VRAM port between three requesters: the VGA scanout read path, a host read/write port for the SHA processor framebuffer writer, and an optional screen-fill engine. The display has absolute priority, so scanout never stalls. Read data returns through a tag pipeline to whichever requester issued the read.

## Interface
- ADDR_W, 18, VRAM word address width
- DATA_W, 16, VRAM word width
- FB_WORDS, 76800, framebuffer size in words; also the fill range
- RD_LAT, 2, VRAM read latency in cycles, from the mem_addr cycle to valid mem_rdata
- CLOCK_50  in  1  system clock; all logic is on its rising edge
- RESET  in  1  synchronous, active-high reset
- disp_req  in  1  display read request, single-cycle pulse
- disp_addr  in  ADDR_W  display read address
- disp_data  out  DATA_W  display read data
- disp_valid  out  1  disp_data valid, 1 cycle
- host_req  in  1  host request; held with host_we, host_addr and host_wdata stable until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  access on the memory bus this cycle
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid, 1 cycle
- fill_start  in  1  start fill (VRAM_FILL_EN only)
- fill_value  in  DATA_W  fill word, captured at start (VRAM_FILL_EN only)
- fill_busy  out  1  fill in progress (VRAM_FILL_EN only)
- mem_addr  out  ADDR_W  VRAM address
- mem_wdata  out  DATA_W  VRAM write data
- mem_we  out  1  VRAM write enable
- mem_rdata  in  DATA_W  VRAM read data

## Operation
- Arbitration happens at each edge k and is registered. The winner drives mem_* during cycle k+1.
- Priority order: display, then host, then fill.
- The host is not eligible at an edge where host_gnt=1. This prevents double-granting a request that is still held. Host throughput is therefore at most 1 access per 2 cycles.
- Display contract: disp_req is asserted at most every other cycle, matching the 25 MHz pixel cadence. This guarantees the host a slot at least every 2 cycles.
- disp_req and host_req in the same cycle: display wins. host_req stays held and the host is granted at the next edge.
- Reads push a tag into a (1+RD_LAT)-deep shift register. Tags are NONE, DISP and HOST.
  - At the pipe output, DISP loads disp_data and pulses disp_valid.
  - HOST loads host_rdata and pulses host_rvalid.
  - Writes push NONE.
- Idle cycle: mem_we=0. mem_addr and mem_wdata hold their previous values.
- Reset values: every output is 0, the tag pipe is cleared to NONE, and the fill FSM is IDLE. Reads in flight when RESET asserts never produce a valid pulse.

## Timing
- Display read: disp_req at edge k → mem_addr in cycle k+1 → disp_valid at cycle k+1+RD_LAT (3 cycles with the defaults).
- Host access: host_gnt is high in the same cycle as mem_addr and mem_we. The host may change or drop its request after that edge.
- Host read: host_rvalid arrives RD_LAT cycles after the host_gnt cycle.
- Fill FSM:
  - IDLE: fill_start captures fill_value, sets the address counter to 0, and moves to RUN.
  - RUN: every slot the fill wins writes fill_value to the counter address, then increments the counter.
  - The write at FB_WORDS-1 returns the FSM to IDLE. fill_busy falls in the following cycle.
  - fill_start during RUN is ignored.
  - The fill counter never wraps.

## Configuration
- VRAM_FILL_EN defined: the fill engine is compiled in, with the fill ports, the FSM, and the lowest-priority fill slot.
- VRAM_FILL_EN undefined:
  - The fill ports are absent.
  - Arbitration covers only display and host.
  - Behaviour is otherwise identical.

## Structure
- Package vram_arb_pkg:
  - tag enum (TAG_NONE, TAG_DISP, TAG_HOST)
  - fill state enum (FILL_IDLE, FILL_RUN)
  - default ADDR_W, DATA_W and FB_WORDS constants
- Sub-module vram_fill_engine contains the fill FSM and address counter, and exposes a req/gnt pair toward the arbiter. It is instantiated only under VRAM_FILL_EN.

## Test plan
- Reset: hold RESET for 3 cycles with random inputs → every output is 0 and no valid pulses occur.
- Display read: preload 0x00100=0xABCD, disp_req at edge 10 → mem_addr=0x00100 in cycle 11, disp_valid with disp_data=0xABCD at cycle 13.
- Collision: disp_req and host_req (write 0x00200←0x1234) at the same edge → display issued first; host_gnt, mem_we=1, mem_addr=0x00200 and mem_wdata=0x1234 one cycle later.
- Sustained load: disp_req every other cycle plus a queue of 8 host writes → all 8 granted within 16 cycles, every disp_valid exactly 3 cycles after its disp_req, and a readback matches.
- Fill (FB_WORDS=16, VRAM_FILL_EN): fill_start with value 0x5A5A → 16 writes to addresses 0..15. A host write injected mid-fill wins its slot. fill_busy drops after the write to address 15, and all 16 words read back as 0x5A5A except the host-written word.
- Reset mid-read: RESET asserted the cycle after the host read's host_gnt → no host_rvalid, and all outputs 0 after reset.
